// File: rtl/shift_deserializer_ctrl.sv
// LSB-first serial-to-parallel frame controller.
// Fills a SIZE-bit shift register and holds each word on a valid/ready port.
module shift_deserializer_ctrl #(
  parameter int SIZE      = 8,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 in,
  input  logic                 in_valid,
  input  logic                 out_ready,
  output logic [SIZE-1:0]      out,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 overrun,
  output logic [CNT_WIDTH-1:0] bit_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(SIZE - 1);

  logic [1:0]           state_q, state_d;
  logic [SIZE-1:0]      out_q, out_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovr_q, ovr_d;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          cnt_d   = '0;
          ovr_d   = 1'b0;
        end
      end
      SHIFT: begin
        if (in_valid) begin
          out_d = {in, out_q[SIZE-1:1]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = HOLD;
        end
      end
      HOLD: begin
        if (in_valid) ovr_d = 1'b1;
        // an accepted start clears overrun even if a bit arrives that edge
        if (out_ready) begin
          if (start) begin
            state_d = SHIFT;
            cnt_d   = '0;
            ovr_d   = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      out_q   <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out       = out_q;
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q == SHIFT);
  assign overrun   = ovr_q;
  assign bit_count = cnt_q;

endmodule

// File: tb/tb_shift_deserializer_ctrl.sv
// Self-checking bench for shift_deserializer_ctrl.
// Compares against a queue-based frame model every cycle.
module tb_shift_deserializer_ctrl;

  localparam int SIZE = 8;
  localparam int CW   = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic            in = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic [SIZE-1:0] out;
  logic            out_valid;
  logic            busy;
  logic            overrun;
  logic [CW-1:0]   bit_count;

  int n_checks = 0;
  int n_pass   = 0;

  shift_deserializer_ctrl #(.SIZE(SIZE), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .in(in),
    .in_valid(in_valid), .out_ready(out_ready), .out(out),
    .out_valid(out_valid), .busy(busy), .overrun(overrun),
    .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  // model: phase 0 idle, 1 collecting, 2 word pending
  int              m_phase = 0;
  bit              m_bits[$];
  logic [SIZE-1:0] m_base = '0;
  bit              m_ovr = 1'b0;

  function automatic logic [SIZE-1:0] m_out();
    logic [SIZE-1:0] v;
    int k;
    k = m_bits.size();
    v = (k >= SIZE) ? '0 : (m_base >> k);
    for (int i = 0; i < k; i++)
      if (m_bits[i]) v = v | (SIZE'(1) << (SIZE - k + i));
    return v;
  endfunction

  task automatic m_update();
    if (reset) begin
      m_phase = 0;
      m_bits.delete();
      m_base = '0;
      m_ovr = 1'b0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_base = m_out();
        m_bits.delete();
        m_ovr = 1'b0;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (in_valid) begin
        m_bits.push_back(in);
        if (m_bits.size() == SIZE) m_phase = 2;
      end
    end else begin
      if (in_valid) m_ovr = 1'b1;
      if (out_ready) begin
        if (start) begin
          m_base = m_out();
          m_bits.delete();
          m_ovr = 1'b0;
          m_phase = 1;
        end else begin
          m_phase = 0;
        end
      end
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic compare();
    chk("out", 32'(out), 32'(m_out()));
    chk("out_valid", 32'(out_valid), 32'(m_phase == 2));
    chk("busy", 32'(busy), 32'(m_phase == 1));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("bit_count", 32'(bit_count), 32'(m_bits.size()));
  endtask

  // drive one cycle's inputs, advance the model at the edge, check after
  task automatic tick(bit s, bit v, bit b, bit r, bit rst);
    start = s; in_valid = v; in = b; out_ready = r; reset = rst;
    @(posedge clk);
    m_update();
    @(negedge clk);
    compare();
  endtask

  task automatic send_bits(logic [SIZE-1:0] w, int gaps, bit st);
    int left;
    left = gaps;
    for (int i = 0; i < SIZE; i++) begin
      if (i > 0 && left > 0 && $urandom_range(0, SIZE - 1 - i) < left) begin
        tick(st, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("gap_no_valid", 32'(out_valid), 32'd0);
        left--;
      end
      tick(st, 1'b1, w[i], 1'b0, 1'b0);
    end
  endtask

  initial begin
    @(negedge clk);
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 1);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_cnt", 32'(bit_count), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);

    // basic frame
    tick(1, 0, 0, 0, 0);
    send_bits(8'h4D, 0, 0);
    chk("basic_out", 32'(out), 32'h4D);
    chk("basic_valid", 32'(out_valid), 32'd1);
    chk("basic_cnt", 32'(bit_count), 32'd8);
    chk("basic_busy", 32'(busy), 32'd0);
    tick(0, 0, 0, 1, 0);
    chk("basic_drop", 32'(out_valid), 32'd0);
    chk("basic_keep", 32'(out), 32'h4D);

    // ignored bits in idle, then gapped frame
    tick(0, 1, 1, 0, 0);
    tick(0, 1, 0, 0, 0);
    chk("idle_cnt", 32'(bit_count), 32'd8);
    tick(1, 1, 1, 0, 0);
    send_bits(8'h4D, 3, 0);
    chk("gap_out", 32'(out), 32'h4D);
    tick(0, 0, 0, 1, 0);

    // backpressure and overrun
    tick(1, 0, 0, 0, 0);
    send_bits(8'hA5, 0, 0);
    for (int i = 0; i < 5; i++) tick(0, (i == 1 || i == 3), 1, 0, 0);
    chk("bp_out", 32'(out), 32'hA5);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_ovr", 32'(overrun), 32'd1);
    tick(1, 1, 0, 1, 0);
    chk("bp_busy", 32'(busy), 32'd1);
    chk("bp_ovr_clr", 32'(overrun), 32'd0);
    chk("bp_cnt", 32'(bit_count), 32'd0);
    chk("bp_valid_clr", 32'(out_valid), 32'd0);

    // back-to-back frames, start pulses ignored in shift
    send_bits(8'h3C, 0, 1);
    chk("b2b_first", 32'(out), 32'h3C);
    tick(1, 0, 0, 1, 0);
    chk("b2b_busy", 32'(busy), 32'd1);
    send_bits(8'hC3, 2, 1);
    chk("b2b_second", 32'(out), 32'hC3);
    chk("b2b_valid", 32'(out_valid), 32'd1);
    tick(0, 0, 0, 1, 0);

    // reset mid-frame
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick(0, 1, 1, 0, 0);
    chk("mid_cnt", 32'(bit_count), 32'd4);
    tick(0, 1, 1, 0, 1);
    chk("mid_rst_out", 32'(out), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cnt", 32'(bit_count), 32'd0);

    // reset while holding
    tick(1, 0, 0, 0, 0);
    send_bits(8'hFF, 0, 0);
    tick(0, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 1);
    chk("hold_rst_valid", 32'(out_valid), 32'd0);
    chk("hold_rst_ovr", 32'(overrun), 32'd0);
    chk("hold_rst_out", 32'(out), 32'd0);
    tick(1, 0, 0, 0, 0);
    send_bits(8'h81, 1, 0);
    chk("post_rst_out", 32'(out), 32'h81);
    tick(0, 0, 0, 1, 0);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      tick($urandom_range(0, 3) == 0,
           $urandom_range(0, 3) != 0,
           1'($urandom),
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 99) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
